// File: rtl/fc_mul_scheduler.sv
// Round-robin arbiter sharing one multi-cycle Booth multiplier among NREQ requesters.
// Sequences the multiplier's enable/reset protocol and aborts a multiply that never finishes.
module fc_mul_scheduler #(
  parameter int N       = 16,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_m,
  input  logic [NREQ*N-1:0] req_r,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err,
  output logic              busy,
  output logic              err_sticky,
  output logic [N-1:0]      mul_m,
  output logic [N-1:0]      mul_r,
  output logic              mul_enable,
  output logic              mul_reset,
  input  logic              mul_finish,
  input  logic [15:0]       mul_result
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [WDW-1:0] wdog;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  int             slot;

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    slot        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      slot = int'(ptr) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      if (!grant_found && req_valid[PW'(slot)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(slot);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && state == S_IDLE && grant_found) req_ready[PW'(grant_idx)] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == S_DONE) rsp_valid[PW'(rsp_id)] = 1'b1;
  end

  assign busy       = (state != S_IDLE);
  assign mul_enable = (state == S_LOAD) || (state == S_RUN);
  assign mul_reset  = (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= IDW'(NREQ - 1);
      wdog       <= '0;
      mul_m      <= '0;
      mul_r      <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            mul_m  <= req_m[int'(grant_idx)*N +: N];
            mul_r  <= req_r[int'(grant_idx)*N +: N];
            rsp_id <= grant_idx;
            ptr    <= grant_idx;
            state  <= S_LOAD;
          end
        end
        // finish may still be high from the previous op here, so it is not looked at
        S_LOAD: begin
          wdog  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          wdog <= wdog + WDW'(1);
          if (mul_finish) begin
            rsp_data <= mul_result;
            rsp_err  <= 1'b0;
            state    <= S_DONE;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            rsp_data   <= '0;
            rsp_err    <= 1'b1;
            err_sticky <= 1'b1;
            state      <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mul_scheduler.sv
// Directed + randomized bench for fc_mul_scheduler, with a behavioural multiplier stub
// and a transaction-level model of grant order, latency, product and error flags.
module tb_fc_mul_scheduler;
  localparam int N = 16, NREQ = 4, IDW = 2, TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_m, req_r;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [15:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err, busy, err_sticky;
  logic [N-1:0]      mul_m, mul_r;
  logic              mul_enable, mul_reset;
  logic              mul_finish = 1'b0;
  logic [15:0]       mul_result;

  logic [N-1:0] opm [NREQ];
  logic [N-1:0] opr [NREQ];

  int checks = 0, errors = 0, cyc = 0;
  int ptr_m = NREQ - 1;
  bit sticky_m = 0;

  fc_mul_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_m(req_m), .req_r(req_r),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy), .err_sticky(err_sticky), .mul_m(mul_m), .mul_r(mul_r),
    .mul_enable(mul_enable), .mul_reset(mul_reset), .mul_finish(mul_finish),
    .mul_result(mul_result));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      req_m[j*N +: N] = opm[j];
      req_r[j*N +: N] = opr[j];
    end
  end

  function automatic logic [15:0] fixmul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[25:10];
  endfunction

  // Multiplier stub: finish rises stub_lat enabled cycles after start, held until next start.
  int stub_lat = N + 1;
  int scnt = 0;
  logic [N-1:0] sm = '0, sr = '0;
  always @(posedge clk) begin
    if (mul_enable && mul_reset) begin
      scnt <= 0; mul_finish <= 1'b0; sm <= mul_m; sr <= mul_r;
    end else if (mul_enable && !mul_finish) begin
      scnt <= scnt + 1;
      if (scnt + 1 == stub_lat) mul_finish <= 1'b1;
    end
  end
  assign mul_result = fixmul(sm, sr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_pt();
    @(posedge clk); #2;
  endtask

  function automatic int next_grant(input int p, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rspv"}, rsp_valid, 0);
    chk({tag, "_data"}, rsp_data, 0);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sticky"}, err_sticky, 0);
    chk({tag, "_mulm"}, mul_m, 0);
    chk({tag, "_mulr"}, mul_r, 0);
    chk({tag, "_en"}, mul_enable, 0);
    chk({tag, "_rst"}, mul_reset, 0);
  endtask

  // Called at a drive point with req_valid already set; returns at the DONE sample point.
  task automatic run_op(input int lat, input bit hold, output int g, output int t0);
    int n, k, fvis, done_at;
    bit err;
    logic [15:0] m, r;
    g = next_grant(ptr_m, req_valid);
    #1;
    n = 0;
    while (req_ready == 0 && n < 80) begin @(posedge clk); #3; n++; end
    chk("grant", req_ready, 32'(1) << g);
    chk("busy_idle", busy, 0);
    t0 = cyc; ptr_m = g; m = opm[g]; r = opr[g];
    fvis = lat + 2;
    err = fvis > TIMEOUT + 1;
    done_at = (err ? TIMEOUT + 1 : fvis) + 1;
    sticky_m |= err;
    stub_lat = lat;
    drive_pt();
    if (!hold) req_valid[g] = 1'b0;
    #1;
    k = 1;
    while (rsp_valid == 0 && k < 200) begin
      chk("no_ready_busy", req_ready, 0);
      chk("busy_op", busy, 1);
      chk("mul_reset", mul_reset, k == 1);
      if (k == 1) begin
        chk("mul_en_load", mul_enable, 1);
        chk("mul_m", mul_m, m);
        chk("mul_r", mul_r, r);
      end
      @(posedge clk); #3; k++;
    end
    chk("rsp_cycle", k, done_at);
    chk("rsp_valid", rsp_valid, 32'(1) << g);
    chk("rsp_id", rsp_id, g);
    chk("rsp_data", rsp_data, err ? 16'h0 : fixmul(m, r));
    chk("rsp_err", rsp_err, err);
    chk("sticky", err_sticky, sticky_m);
    chk("en_done", mul_enable, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int g, t0, tprev;
    int order [5] = '{0, 1, 2, 3, 0};
    for (int j = 0; j < NREQ; j++) begin opm[j] = '0; opr[j] = '0; end

    // reset state, including a request held during reset
    req_valid = 4'b0101;
    repeat (3) drive_pt();
    #1; chk_all_zero("reset");
    req_valid = '0;
    drive_pt(); reset = 1'b1;

    // single op: 1.0 x -2.0
    drive_pt();
    opm[0] = 16'h0400; opr[0] = 16'hF800; req_valid = 4'b0001;
    run_op(N + 1, 0, g, t0);
    chk("single_data", rsp_data, 16'hF800);

    // stale finish: stub finish still high from the previous op during LOAD
    drive_pt();
    opm[0] = 16'h0C00; opr[0] = 16'h0200; req_valid = 4'b0001;
    chk("stale_fin", mul_finish, 1);
    run_op(N + 1, 0, g, t0);

    // reset pulse, then contention 1111 held
    drive_pt(); reset = 1'b0;
    drive_pt(); reset = 1'b1; ptr_m = NREQ - 1;
    drive_pt();
    for (int j = 0; j < NREQ; j++) begin opm[j] = 16'(j * 16'h0300 + 16'h0100); opr[j] = 16'(16'hFE00 - j * 16'h0180); end
    req_valid = 4'b1111;
    tprev = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) drive_pt();
      run_op(N + 1, 1, g, t0);
      chk("cont_order", g, order[i]);
      if (i > 0) chk("cont_spacing", t0 - tprev, 21);
      tprev = t0;
    end
    drive_pt(); req_valid = '0;

    // round-robin skip: last grant 1, then 1010 held -> 3, 1
    drive_pt(); req_valid = 4'b0010;
    run_op(N + 1, 0, g, t0);
    drive_pt(); req_valid = 4'b1010;
    run_op(N + 1, 1, g, t0); chk("skip_a", g, 3);
    drive_pt();
    run_op(N + 1, 0, g, t0); chk("skip_b", g, 1);
    drive_pt(); req_valid = '0;

    // finish exactly on the timeout cycle wins; one cycle later times out
    drive_pt(); req_valid = 4'b0100;
    run_op(TIMEOUT - 1, 0, g, t0);
    chk("prio_err", rsp_err, 0);
    drive_pt(); req_valid = 4'b0100;
    run_op(TIMEOUT, 0, g, t0);

    // hard timeout, then a normal op keeps sticky
    drive_pt(); opm[1] = 16'h0800; opr[1] = 16'h0600; req_valid = 4'b0010;
    run_op(1000, 0, g, t0);
    chk("to_cycle", cyc - t0, 1 + TIMEOUT + 1);
    chk("to_err", rsp_err, 1);
    drive_pt(); req_valid = 4'b0010;
    run_op(N + 1, 0, g, t0);
    chk("sticky_hold", err_sticky, 1);

    // randomized ops
    for (int i = 0; i < 12; i++) begin
      drive_pt();
      for (int j = 0; j < NREQ; j++)
        if (!req_valid[j] && $urandom_range(1) == 1) begin
          req_valid[j] = 1'b1; opm[j] = 16'($urandom); opr[j] = 16'($urandom);
        end
      if (req_valid == 0) req_valid[$urandom_range(NREQ - 1)] = 1'b1;
      run_op(($urandom_range(5) == 0) ? TIMEOUT + 3 : int'($urandom_range(N + 9, N + 1)), 0, g, t0);
    end
    drive_pt(); req_valid = '0;

    // reset mid-RUN at cycle 8
    drive_pt(); opm[2] = 16'h1000; opr[2] = 16'h0400; req_valid = 4'b0100;
    #1; chk("mr_accept", req_ready, 4'b0100);
    t0 = cyc;
    drive_pt(); req_valid = '0;
    while (cyc - t0 < 8) drive_pt();
    reset = 1'b0;
    drive_pt(); reset = 1'b1;
    #1; chk_all_zero("midreset");
    ptr_m = NREQ - 1; sticky_m = 0;
    for (int i = 0; i < 25; i++) begin drive_pt(); #1; chk("mr_no_rsp", rsp_valid, 0); end
    drive_pt();
    opm[0] = 16'h0C00; opr[0] = 16'h0200; req_valid = 4'b1111;
    run_op(N + 1, 0, g, t0);
    chk("mr_first", g, 0);
    chk("mr_data", rsp_data, 16'h0600);
    drive_pt(); req_valid = '0;
    repeat (3) drive_pt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_mul_scheduler.md
Name: fc_mul_scheduler

Overview:
- Round-robin scheduler that shares one multi-cycle Booth multiplier between NREQ requesters, such as FC neuron lanes.
- Accepts one operand pair at a time and sequences the multiplier's enable/reset protocol.
- Waits for the multiplier's finish, then returns the 16-bit fixed-point product to the winning requester with its ID.
- Includes a watchdog that aborts a multiply which never finishes.

Parameters:
- N, 16, operand width; must match the multiplier's N.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester-ID width; must be at least clog2(NREQ).
- TIMEOUT, 64, RUN cycles allowed before abort; must be greater than N+2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request, level-held until accepted.
- req_m  in  NREQ*N  multiplicand, requester i at [i*N +: N].
- req_r  in  NREQ*N  multiplier operand, same packing.
- req_ready  out  NREQ  one-hot, 1-cycle accept pulse.
- rsp_valid  out  NREQ  one-hot, 1-cycle result pulse.
- rsp_data  out  16  signed fixed-point product, shared bus.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_err  out  1  qualifies rsp_valid: 1 means timeout abort.
- busy  out  1  high in every state except IDLE.
- err_sticky  out  1  set on any timeout; cleared only by reset.
- mul_m  out  N  operand to multiplier M.
- mul_r  out  N  operand to multiplier R.
- mul_enable  out  1  multiplier enable.
- mul_reset  out  1  multiplier start/reset (active high, sampled only with enable).
- mul_finish  in  1  multiplier finish; level, stays high until next mul_reset.
- mul_result  in  16  multiplier fixedMulResult.

Behaviour:
- Reset (reset=0 at edge):
  - State goes to IDLE; rr pointer = NREQ-1, so requester 0 wins first.
  - All outputs 0: req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, err_sticky, mul_m, mul_r, mul_enable, mul_reset.
  - Watchdog counter = 0.
  - Reset applied mid-operation abandons the current op with no response; the multiplier is re-initialised by the next LOAD.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching from pointer+1 upward, wrapping modulo NREQ.
  - req_ready[g]=1 this cycle (combinational from state and req_valid).
  - At the edge: latch req_m/req_r slice g into mul_m/mul_r, latch g into rsp_id, set pointer=g, go to LOAD.
  - No request: stay in IDLE.
- LOAD (exactly 1 cycle):
  - mul_enable=1, mul_reset=1; watchdog cleared.
  - mul_finish is ignored here, since it may be stale from the previous op.
  - Next state: RUN.
- RUN:
  - mul_enable=1, mul_reset=0; watchdog increments each cycle.
  - mul_finish=1: capture mul_result into rsp_data, rsp_err=0, go to DONE.
  - Otherwise, watchdog == TIMEOUT-1: rsp_data=0, rsp_err=1, err_sticky=1, go to DONE.
  - Finish has priority when it coincides with the timeout cycle.
- DONE (1 cycle):
  - rsp_valid[rsp_id]=1; rsp_data, rsp_id and rsp_err are valid.
  - mul_enable=0, so the multiplier holds its value.
  - Next state: IDLE. rsp_data/rsp_id hold until the next capture.
- Latency:
  - Accept cycle = cycle 0; LOAD = cycle 1.
  - The multiplier iterates on RUN cycles 2..N+1 and raises finish visible in cycle N+3.
  - DONE / rsp_valid at cycle N+4 (20 for N=16).
  - Throughput: one product per N+5 cycles, because IDLE always intervenes.
- Fairness:
  - The pointer advances only on a grant.
  - A continuously requesting requester waits at most NREQ-1 grants.
- Requester rules:
  - Operands must be stable while req_valid=1 and req_ready=0.
  - A requester may re-request in the cycle after its req_ready pulse.
  - req_valid falling before grant is legal; that request is simply not served.
- Outputs are one-hot or zero:
  - req_ready and rsp_valid never have more than one bit set.
  - req_ready is never 1 outside IDLE.
- busy=1 in LOAD, RUN and DONE.

Test Plan:
- Single op: req_valid=0001, M=0x0400 (1.0), R=0xF800 (-2.0) -> req_ready=0001 in cycle 0; mul_reset pulse in cycle 1; rsp_valid=0001 in cycle 20; rsp_data=0xF800, rsp_id=0, rsp_err=0.
- Contention: req_valid=1111 held, distinct operands -> grant order 0,1,2,3,0; each rsp_id matches its grant; successive req_ready pulses spaced 21 cycles.
- Round-robin skip: req_valid=1010 after last grant=1 -> next grant 3, then 1; requesters 0 and 2 never pulsed.
- Timeout: multiplier stub holds finish=0 -> rsp_valid in cycle 1+TIMEOUT+1 with rsp_err=1, rsp_data=0, err_sticky=1. A following normal op completes with rsp_err=0 and err_sticky still 1.
- Stale finish: stub keeps finish=1 through LOAD (drops on mul_reset) -> no early DONE; result still arrives in cycle 20.
- Reset mid-RUN: assert reset=0 at cycle 8 for 1 cycle -> all outputs 0, no rsp_valid; a request re-issued afterwards is served by requester 0 first with a correct product (3.0 x 0.5 -> 0x0600).
